// File: rtl/data_sram_resp.sv
// Data-port responder: 2^RAM_AW x 32 RAM plus a small MMIO block (LED, switch,
// timer, scratch, RAM write counter) decoded at 0xBFAF_xxxx.
module data_sram_resp #(
  parameter int RAM_AW     = 10,
  parameter int TIMER_STEP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam logic [13:0] OFF_LED      = 14'h3C00;
  localparam logic [13:0] OFF_SWITCH   = 14'h3C01;
  localparam logic [13:0] OFF_TIMER    = 14'h3C02;
  localparam logic [13:0] OFF_SCRATCH  = 14'h3C03;
  localparam logic [13:0] OFF_WR_COUNT = 14'h3C04;

  logic [31:0]       mem [2**RAM_AW];
  logic [31:0]       timer;
  logic [31:0]       scratch;
  logic [31:0]       wr_count;
  logic [31:0]       mmio_rd;
  logic              mmio;
  logic              ram_we;
  logic [13:0]       off;
  logic [RAM_AW-1:0] idx;
  logic              unused_addr_bits;

  assign mmio   = (data_sram_addr[31:16] == 16'hBFAF);
  assign off    = data_sram_addr[15:2];
  assign idx    = data_sram_addr[RAM_AW+1:2];
  assign ram_we = data_sram_we && !mmio;
  assign unused_addr_bits = &{1'b0, data_sram_addr[1:0]};

  always_comb begin
    mmio_rd = 32'h0;
    case (off)
      OFF_LED:      mmio_rd = {16'h0, led};
      OFF_SWITCH:   mmio_rd = {24'h0, switch};
      OFF_TIMER:    mmio_rd = timer;
      OFF_SCRATCH:  mmio_rd = scratch;
      OFF_WR_COUNT: mmio_rd = wr_count;
      default:      mmio_rd = 32'h0;
    endcase
  end

  // RAM has no reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (resetn && ram_we)
      mem[idx] <= data_sram_wdata;
  end

  // Nonblocking read of mem alongside the write above gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_sram_rdata <= 32'h0;
      led             <= 16'h0;
      timer           <= 32'h0;
      scratch         <= 32'h0;
      wr_count        <= 32'h0;
    end else begin
      data_sram_rdata <= mmio ? mmio_rd : mem[idx];

      if (ram_we)
        wr_count <= wr_count + 32'd1;

      if (data_sram_we && mmio && off == OFF_LED)
        led <= data_sram_wdata[15:0];

      if (data_sram_we && mmio && off == OFF_SCRATCH)
        scratch <= data_sram_wdata;

      if (data_sram_we && mmio && off == OFF_TIMER)
        timer <= data_sram_wdata;
      else
        timer <= timer + 32'(TIMER_STEP);
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: RAM, read-first, aliasing, MMIO, timer wrap, reset.
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;

  int n_checks = 0;
  int n_errors = 0;

  data_sram_resp #(.RAM_AW(10), .TIMER_STEP(1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, then let one rising edge take them; returns 1 time unit after it.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    data_sram_we    = we;
    data_sram_addr  = a;
    data_sram_wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    switch = 8'h00;
    cyc(1'b1, 32'h0000_0040, 32'hFFFF_FFFF);
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);

    // First edge out of reset reads TIMER as 0, next read sees 1.
    resetn = 1'b1;
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("timer_first", data_sram_rdata, 32'h0);
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("timer_second", data_sram_rdata, 32'h1);

    // RAM write then read
    cyc(1'b1, 32'h1C00_0010, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h1C00_0010, 32'h0);
    check("ram_rd", data_sram_rdata, 32'hDEAD_BEEF);
    cyc(1'b0, 32'hBFAF_F010, 32'h0);
    check("wr_count_1", data_sram_rdata, 32'd1);

    // Read-first collision
    cyc(1'b1, 32'h0000_0020, 32'h1111_1111);
    cyc(1'b1, 32'h0000_0020, 32'h2222_2222);
    check("collide_old", data_sram_rdata, 32'h1111_1111);
    cyc(1'b0, 32'h0000_0020, 32'h0);
    check("collide_new", data_sram_rdata, 32'h2222_2222);

    // Aliasing above RAM_AW
    cyc(1'b1, 32'h0000_0004, 32'hA5A5_A5A5);
    cyc(1'b0, 32'h0000_1004, 32'h0);
    check("alias", data_sram_rdata, 32'hA5A5_A5A5);

    // LED / SWITCH
    cyc(1'b1, 32'hBFAF_F000, 32'hFFFF_1234);
    check("led_out", {16'h0, led}, 32'h0000_1234);
    cyc(1'b0, 32'hBFAF_F000, 32'h0);
    check("led_rd", data_sram_rdata, 32'h0000_1234);
    switch = 8'h5A;
    cyc(1'b0, 32'hBFAF_F004, 32'h0);
    check("switch_rd", data_sram_rdata, 32'h0000_005A);
    cyc(1'b1, 32'hBFAF_F004, 32'hFFFF_FFFF);
    check("switch_wr_led", {16'h0, led}, 32'h0000_1234);
    cyc(1'b0, 32'hBFAF_F004, 32'h0);
    check("switch_wr_rd", data_sram_rdata, 32'h0000_005A);
    cyc(1'b0, 32'hBFAF_F000, 32'h0);
    check("led_kept", data_sram_rdata, 32'h0000_1234);

    // Undefined offset and SCRATCH
    cyc(1'b1, 32'hBFAF_F014, 32'hCAFE_F00D);
    cyc(1'b0, 32'hBFAF_F014, 32'h0);
    check("undef_rd", data_sram_rdata, 32'h0);
    cyc(1'b1, 32'hBFAF_F00C, 32'h1234_5678);
    cyc(1'b0, 32'hBFAF_F00C, 32'h0);
    check("scratch_rd", data_sram_rdata, 32'h1234_5678);

    // Timer load and wrap; MMIO writes above did not count
    cyc(1'b1, 32'hBFAF_F008, 32'hFFFF_FFFE);
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("timer_load", data_sram_rdata, 32'hFFFF_FFFE);
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("timer_inc", data_sram_rdata, 32'hFFFF_FFFF);
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);
    cyc(1'b0, 32'hBFAF_F010, 32'h0);
    check("wr_count_4", data_sram_rdata, 32'd4);

    // Reset mid-operation with a read in flight and a write strobe asserted
    cyc(1'b1, 32'h0000_0040, 32'h0000_0055);
    cyc(1'b0, 32'hBFAF_F010, 32'h0);
    check("wr_count_5", data_sram_rdata, 32'd5);
    cyc(1'b0, 32'h0000_0040, 32'h0);
    check("pre_rst_rd", data_sram_rdata, 32'h0000_0055);
    resetn = 1'b0;
    cyc(1'b1, 32'h0000_0040, 32'h9999_9999);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    resetn = 1'b1;
    cyc(1'b0, 32'h0000_0040, 32'h0);
    check("rst_ram_kept", data_sram_rdata, 32'h0000_0055);
    cyc(1'b0, 32'hBFAF_F010, 32'h0);
    check("rst_wr_count", data_sram_rdata, 32'h0);
    cyc(1'b0, 32'hBFAF_F00C, 32'h0);
    check("rst_scratch", data_sram_rdata, 32'h0);
    cyc(1'b0, 32'hBFAF_F008, 32'h0);
    check("rst_timer", data_sram_rdata, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning RAM word-address width (2^RAM_AW x 32-bit words).
REQ-002 SHALL have parameter TIMER_STEP, default 1, meaning the timer increment per cycle.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning the reset, which is synchronous and active-low.
REQ-005 SHALL have port data_sram_we, input, 1, meaning the write strobe from the CPU data port.
REQ-006 SHALL have port data_sram_addr, input, 32, meaning the byte address; bits [1:0] are ignored.
REQ-007 SHALL have port data_sram_wdata, input, 32, meaning the write data.
REQ-008 SHALL have port data_sram_rdata, output, 32, meaning the registered read data.
REQ-009 SHALL have port led, output, 16, meaning the LED register value.
REQ-010 SHALL have port switch, input, 8, meaning the switch levels, sampled when read.

Function
REQ-011 SHALL decode addresses with addr[31:16]==16'hBFAF as MMIO and all other addresses as RAM.
REQ-012 SHALL index RAM by addr[RAM_AW+1:2]; higher address bits alias.
REQ-013 SHALL write wdata to the selected RAM word or MMIO register at an edge where we=1 and resetn=1.
REQ-014 SHALL give reads a 1-cycle latency: rdata after edge N reflects the addr sampled at edge N, every cycle, regardless of we.
REQ-015 SHALL be read-first: when the read and write address match at the same edge, rdata returns the pre-write value.
REQ-016 SHALL use MMIO offset 0xF000 for LED, RW, 16 bits: writes take wdata[15:0], reads return {16'h0, led}.
REQ-017 SHALL use MMIO offset 0xF004 for SWITCH, RO: reads return {24'h0, switch}, writes are ignored.
REQ-018 SHALL use MMIO offset 0xF008 for TIMER, RW, 32 bits: free-running, +TIMER_STEP each cycle, wraps modulo 2^32; a write loads wdata with no increment that cycle.
REQ-019 SHALL use MMIO offset 0xF00C for SCRATCH, RW, 32 bits.
REQ-020 SHALL use MMIO offset 0xF010 for WR_COUNT, RO, 32 bits: +1 on every RAM write, wraps modulo 2^32; MMIO writes do not count it.
REQ-021 SHALL return 32'h0 for reads of undefined MMIO offsets and SHALL ignore writes to them.
REQ-022 SHALL return the pre-edge register value when TIMER is read: on the same-edge read of a TIMER write, it returns the old value; on the next read, it returns the loaded value plus TIMER_STEP per elapsed cycle.
REQ-023 SHALL not reset RAM contents, which are undefined until written.
REQ-024 SHALL produce no X on data_sram_rdata after reset, for any MMIO read, or for any RAM read of a previously written word.

Reset
REQ-025 SHALL, at an edge with resetn=0, set data_sram_rdata=0, led=0, TIMER=0, SCRATCH=0 and WR_COUNT=0.
REQ-026 SHALL, during reset, ignore we, perform no RAM write, and hold TIMER at 0.
REQ-027 SHALL start TIMER counting at the first edge with resetn=1; the first TIMER read after reset release returns 0.
REQ-028 SHALL abort any in-flight read when reset is asserted mid-operation; rdata is 0 on the following cycle.

Verification
REQ-029 SHALL cover RAM write then read: write 0x1C00_0010 <- 0xDEAD_BEEF, then read the same address -> rdata=0xDEAD_BEEF one cycle after the read edge; WR_COUNT=1.
REQ-030 SHALL cover read-first collision: RAM word holds 0x1111_1111; at one edge write 0x2222_2222 to it with the same addr -> rdata=0x1111_1111; the next read returns 0x2222_2222.
REQ-031 SHALL cover aliasing: write 0x0000_0004 <- 0xA5A5_A5A5 with RAM_AW=10; read 0x0000_1004 -> 0xA5A5_A5A5.
REQ-032 SHALL cover LED and SWITCH: write 0xBFAF_F000 <- 0xFFFF_1234 -> led=16'h1234, read returns 0x0000_1234; switch=8'h5A, read 0xBFAF_F004 -> 0x0000_005A; write to 0xBFAF_F004 leaves state unchanged.
REQ-033 SHALL cover timer load and wrap: write 0xBFAF_F008 <- 0xFFFF_FFFE, then read on each of the next 3 cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 (TIMER_STEP=1).
REQ-034 SHALL cover reset mid-operation: with SCRATCH=0x1234_5678 and WR_COUNT=5, drive resetn=0 for one edge with we=1 -> all registers and rdata are 0, the RAM target word is unchanged, and WR_COUNT stays 0.
